mem_stage_mc: RTL and testbench

Parametrised successor to the single-cycle MEM stage. Talks to a variable-latency data memory over a req/ack handshake and stalls the pipeline while an access is outstanding. Keeps WB-to-MEM store-data forwarding and adds an internal registered M/WB output bundle. Sits between the X/M pipeline register and the WB stage.

---
 rtl/mem_stage_mc_if.sv | 23 ++
 rtl/mem_stage_mc.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_mc.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_mc_if.sv
// Data-memory request/ack bus between the MEM stage
// (master) and a variable-latency data memory (slave).
interface mem_stage_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: req/ack data memory, pipeline stall, M/WB register.
// Optional access timeout with sticky mem_err: define MEM_TIMEOUT_EN.
module mem_stage_mc #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int REG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_wr_reg,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic              in_halt,
  input  logic              fwd_sel,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              stall,
  mem_stage_mc_if.master    mem,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic              wb_halt,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [REG_W-1:0]  wb_wr_reg,
  output logic              mem_err
);

  if (ADDR_W > DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_stage_mc: bad parameter set");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] alu_q;
  logic [REG_W-1:0]  rd_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic              halt_q;
  logic              is_mem;

  assign is_mem = in_valid & (in_memread | in_memwrite);

  // rst_n gate keeps stall low while reset holds a stale bundle
  assign stall = rst_n &
    (((state == IDLE) & is_mem) |
     ((state == BUSY) & ~mem.mem_ack));

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      alu_q         <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      halt_q        <= 1'b0;
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_halt       <= 1'b0;
      wb_alu_result <= '0;
      wb_mem_data   <= '0;
      wb_wr_reg     <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt           <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (is_mem) begin
            state       <= BUSY;
            req_q       <= 1'b1;
            we_q        <= in_memwrite;
            addr_q      <= in_alu_result[ADDR_W-1:0];
            wdata_q     <= fwd_sel ? fwd_data : in_store_data;
            alu_q       <= in_alu_result;
            rd_q        <= in_wr_reg;
            regwrite_q  <= in_regwrite;
            memtoreg_q  <= in_memtoreg;
            halt_q      <= in_halt;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_halt     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt         <= '0;
`endif
          end else begin
            wb_valid      <= in_valid;
            wb_regwrite   <= in_regwrite & in_valid;
            wb_memtoreg   <= in_memtoreg & in_valid;
            wb_halt       <= in_halt & in_valid;
            wb_alu_result <= in_alu_result;
            wb_wr_reg     <= in_wr_reg;
            wb_mem_data   <= '0;
          end
        end
        BUSY: begin
          wb_valid    <= 1'b0;
          wb_regwrite <= 1'b0;
          wb_halt     <= 1'b0;
          if (mem.mem_ack) begin
            state         <= IDLE;
            req_q         <= 1'b0;
            wb_valid      <= 1'b1;
            wb_regwrite   <= regwrite_q;
            wb_memtoreg   <= memtoreg_q;
            wb_halt       <= halt_q;
            wb_alu_result <= alu_q;
            wb_wr_reg     <= rd_q;
            wb_mem_data   <= we_q ? '0 : mem.mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
          // abandoned access still retires, but never writes a register
          else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            req_q         <= 1'b0;
            wb_valid      <= 1'b1;
            wb_regwrite   <= 1'b0;
            wb_memtoreg   <= memtoreg_q;
            wb_halt       <= halt_q;
            wb_alu_result <= alu_q;
            wb_wr_reg     <= rd_q;
            wb_mem_data   <= '0;
            err_q         <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed + random bench for mem_stage_mc with a
// transaction-level expectation per instruction.
module tb_mem_stage_mc;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_store_data;
  logic [RW-1:0] in_wr_reg;
  logic          in_memread;
  logic          in_memwrite;
  logic          in_regwrite;
  logic          in_memtoreg;
  logic          in_halt;
  logic          fwd_sel;
  logic [DW-1:0] fwd_data;
  logic          stall;
  logic          wb_valid;
  logic          wb_regwrite;
  logic          wb_memtoreg;
  logic          wb_halt;
  logic [DW-1:0] wb_alu_result;
  logic [DW-1:0] wb_mem_data;
  logic [RW-1:0] wb_wr_reg;
  logic          mem_err;

  int total = 0;
  int bad = 0;

  mem_stage_mc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_stage_mc #(
    .DATA_W(DW), .ADDR_W(AW),
    .REG_W(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_alu_result(in_alu_result),
    .in_store_data(in_store_data),
    .in_wr_reg(in_wr_reg),
    .in_memread(in_memread),
    .in_memwrite(in_memwrite),
    .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg),
    .in_halt(in_halt),
    .fwd_sel(fwd_sel),
    .fwd_data(fwd_data),
    .stall(stall),
    .mem(bus),
    .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg),
    .wb_halt(wb_halt),
    .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data),
    .wb_wr_reg(wb_wr_reg),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    in_valid    = 1'b0;
    in_memread  = 1'b0;
    in_memwrite = 1'b0;
    in_regwrite = 1'b0;
    in_memtoreg = 1'b0;
    in_halt     = 1'b0;
    fwd_sel     = 1'b0;
  endtask

  // one non-memory (or empty) slot: retires one edge later
  task automatic do_alu(input logic v,
                        input logic [DW-1:0] res,
                        input logic [RW-1:0] rd,
                        input logic rw,
                        input logic mt,
                        input logic h);
    in_valid      = v;
    in_alu_result = res;
    in_wr_reg     = rd;
    in_regwrite   = rw;
    in_memtoreg   = mt;
    in_halt       = h;
    in_memread    = 1'b0;
    in_memwrite   = 1'b0;
    in_store_data = DW'($urandom);
    fwd_sel       = 1'($urandom);
    fwd_data      = DW'($urandom);
    @(negedge clk);
    chk("alu_stall", stall, 0);
    chk("alu_req", bus.mem_req, 0);
    @(posedge clk); #1;
    chk("alu_wb_valid", wb_valid, v);
    chk("alu_wb_regwrite", wb_regwrite, rw & v);
    chk("alu_wb_halt", wb_halt, h & v);
    if (v) begin
      chk("alu_wb_result", wb_alu_result, res);
      chk("alu_wb_rd", wb_wr_reg, rd);
      chk("alu_wb_memdata", wb_mem_data, 0);
      chk("alu_wb_memtoreg", wb_memtoreg, mt);
    end
  endtask

  // memory op acked in the (k+1)-th busy cycle
  task automatic do_mem(input logic we,
                        input logic both,
                        input logic [DW-1:0] addr,
                        input logic [DW-1:0] sd,
                        input logic [DW-1:0] fd,
                        input logic fs,
                        input logic [RW-1:0] rd,
                        input logic rw,
                        input logic mt,
                        input logic h,
                        input int k,
                        input logic [DW-1:0] rdata);
    logic [DW-1:0] ewd;
    ewd = fs ? fd : sd;
    in_valid      = 1'b1;
    in_memwrite   = we;
    in_memread    = we ? both : 1'b1;
    in_alu_result = addr;
    in_store_data = sd;
    fwd_sel       = fs;
    fwd_data      = fd;
    in_wr_reg     = rd;
    in_regwrite   = rw;
    in_memtoreg   = mt;
    in_halt       = h;
    @(negedge clk);
    chk("entry_stall", stall, 1);
    chk("entry_req_low", bus.mem_req, 0);
    @(posedge clk); #1;
    chk("entry_bubble", wb_valid, 0);
    fwd_data      = DW'($urandom);
    in_store_data = DW'($urandom);
    fwd_sel       = ~fs;
    in_alu_result = DW'($urandom);
    for (int i = 0; i <= k; i++) begin
      bus.mem_ack   = (i == k);
      bus.mem_rdata = (i == k) ? rdata : DW'($urandom);
      @(negedge clk);
      chk("busy_req", bus.mem_req, 1);
      chk("busy_we", bus.mem_we, we);
      chk("busy_addr", bus.mem_addr, addr);
      chk("busy_wdata", bus.mem_wdata, ewd);
      chk("busy_stall", stall, 1'(i != k));
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (i < k) begin
        chk("busy_bubble", wb_valid, 0);
        chk("busy_bubble_rw", wb_regwrite, 0);
      end else begin
        chk("ret_valid", wb_valid, 1);
        chk("ret_regwrite", wb_regwrite, rw);
        chk("ret_memtoreg", wb_memtoreg, mt);
        chk("ret_halt", wb_halt, h);
        chk("ret_alu", wb_alu_result, addr);
        chk("ret_rd", wb_wr_reg, rd);
        chk("ret_mdata", wb_mem_data, we ? 0 : rdata);
        chk("ret_req_low", bus.mem_req, 0);
      end
    end
  endtask

  initial begin
    set_idle();
    in_alu_result = '0;
    in_store_data = '0;
    in_wr_reg     = '0;
    fwd_data      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #12;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rw", wb_regwrite, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_err", mem_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_alu(1, 16'h1234, 4'd3, 1, 0, 0);
    do_mem(0, 0, 16'h0040, 16'h0, 16'h0, 0,
           4'd5, 1, 1, 0, 2, 16'hBEEF);
    do_mem(1, 0, 16'h0100, 16'h1111, 16'hA5A5, 1,
           4'd0, 0, 0, 0, 2, 16'h7777);
    do_mem(0, 0, 16'h0008, 16'h0, 16'h0, 0,
           4'd7, 1, 1, 0, 0, 16'h4321);
    do_mem(1, 0, 16'h000C, 16'h5A5A, 16'h0, 0,
           4'd0, 0, 0, 0, 0, 16'h0);
    do_mem(1, 1, 16'h0020, 16'hC3C3, 16'h0, 0,
           4'd2, 0, 0, 1, 1, 16'h9999);
    do_alu(1, 16'h00FF, 4'd1, 1, 0, 1);
    do_alu(0, 16'hFFFF, 4'd2, 1, 1, 1);

    for (int n = 0; n < 30; n++) begin
      int t;
      t = $urandom_range(0, 3);
      if (t < 2) begin
        do_alu(1'($urandom_range(0, 3) != 0),
               DW'($urandom), RW'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        do_mem(1'(t == 3), 1'($urandom),
               DW'($urandom), DW'($urandom),
               DW'($urandom), 1'($urandom),
               RW'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom),
               $urandom_range(0, 4), DW'($urandom));
      end
    end

`ifdef MEM_TIMEOUT_EN
    in_valid = 1'b1; in_memread = 1'b1;
    in_memwrite = 1'b0; in_regwrite = 1'b1;
    in_memtoreg = 1'b1; in_halt = 1'b0;
    in_alu_result = 16'h0200; in_wr_reg = 4'd9;
    @(negedge clk);
    chk("to_entry_stall", stall, 1);
    @(posedge clk); #1;
    set_idle();
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_busy_req", bus.mem_req, 1);
      chk("to_busy_stall", stall, 1);
      @(posedge clk); #1;
    end
    chk("to_req_drop", bus.mem_req, 0);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_rw", wb_regwrite, 0);
    chk("to_err", mem_err, 1);
    @(negedge clk);
    chk("to_stall_rel", stall, 0);
    @(posedge clk); #1;
    do_alu(1, 16'h0BAD, 4'd4, 1, 0, 0);
    chk("to_err_sticky", mem_err, 1);
`else
    chk("no_err", mem_err, 0);
`endif

    in_valid = 1'b1; in_memread = 1'b1;
    in_memwrite = 1'b0; in_regwrite = 1'b1;
    in_memtoreg = 1'b1; in_halt = 1'b0;
    in_alu_result = 16'h0300; in_wr_reg = 4'd6;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", bus.mem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_err", mem_err, 0);
    set_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("post_rst_req", bus.mem_req, 0);
    chk("post_rst_noret", wb_valid, 0);
    do_alu(1, 16'h5555, 4'd8, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
